pci_bus_arbiter: RTL and testbench

//  Central round-robin arbiter for the shared 32-bit PCI-style addressdata bus.
//  - Collects active-low request from every Device, drives one active-low grant.
//  - Tracks bus ownership through iframe/iready to the end of each transaction.
//  - Inserts a turnaround cycle between owners.

---
 rtl/pci_bus_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_pci_bus_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pci_bus_arbiter.sv
// pci_bus_arbiter: round-robin owner selection for a shared PCI-style bus.
// Requests and grants are active-low. Ownership is followed through FRAME/IRDY
// to the end of each transaction, and a turnaround cycle is inserted between
// owners. Optional grant timeout: define PCI_ARB_GNT_TIMEOUT_EN.
module pci_bus_arbiter #(
   parameter int NUM_DEV     = 3,
   parameter int IDX_W       = 2,
   parameter int GNT_TIMEOUT = 16,
   parameter int CNT_W       = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_DEV-1:0] request,
   input  logic               iframe,
   input  logic               iready,
   output logic [NUM_DEV-1:0] grant,
   output logic [IDX_W-1:0]   owner,
   output logic               owner_valid,
   output logic               bus_busy,
   output logic               timeout
);

   typedef enum logic [1:0] {IDLE, GRANTED, BUSY, TURN} state_t;

   state_t               state_reg, state_next;
   logic [NUM_DEV-1:0]   grant_reg, grant_next;
   logic [IDX_W-1:0]     owner_reg, owner_next;
   logic [IDX_W-1:0]     last_owner_reg, last_owner_next;
   logic                 owner_valid_reg, owner_valid_next;
   logic                 bus_busy_reg, bus_busy_next;

   logic [NUM_DEV-1:0]   req_act;
   logic                 req_any;
   logic                 bus_idle;
   logic [IDX_W-1:0]     winner;

`ifdef PCI_ARB_GNT_TIMEOUT_EN
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(GNT_TIMEOUT);
   logic [CNT_W-1:0]     cnt_reg, cnt_next;
   logic                 timeout_reg, timeout_next;
`endif

   // Configurations that cannot work show up as a named scope in the
   // elaborated hierarchy; a valid build creates no such scope.
   if (NUM_DEV < 2 || NUM_DEV > 8 || (2 ** IDX_W) < NUM_DEV ||
       GNT_TIMEOUT > (2 ** CNT_W) - 1) begin : g_bad_param_cfg
   end

   // Active-high view of the requests, one bit per Device.
   for (genvar gi = 0; gi < NUM_DEV; gi++) begin : g_req
      assign req_act[gi] = ~request[gi];
   end

   assign req_any  = |req_act;
   assign bus_idle = iframe & iready;

   // Round-robin pick: first requester after last_owner, wrapping around.
   always_comb begin
      logic             found;
      logic [IDX_W:0]   cand;
      winner = '0;
      found  = 1'b0;
      cand   = '0;
      for (int k = 1; k <= NUM_DEV; k++) begin
         cand = {1'b0, last_owner_reg} + (IDX_W+1)'(k);
         if (cand >= (IDX_W+1)'(NUM_DEV)) begin
            cand = cand - (IDX_W+1)'(NUM_DEV);
         end
         if (!found && req_act[cand[IDX_W-1:0]]) begin
            found  = 1'b1;
            winner = cand[IDX_W-1:0];
         end
      end
   end

   // Next-state and next-output logic; every output is registered below.
   always_comb begin
      state_next       = state_reg;
      grant_next       = grant_reg;
      owner_next       = owner_reg;
      last_owner_next  = last_owner_reg;
      owner_valid_next = owner_valid_reg;
      bus_busy_next    = bus_busy_reg;
`ifdef PCI_ARB_GNT_TIMEOUT_EN
      cnt_next         = cnt_reg;
      timeout_next     = 1'b0;
`endif
      case (state_reg)
         IDLE: begin
            grant_next       = '1;
            owner_valid_next = 1'b0;
            bus_busy_next    = 1'b0;
            // A foreign/stray transaction on the bus blocks any new grant.
            if (req_any && bus_idle) begin
               state_next       = GRANTED;
               grant_next       = ~(NUM_DEV'(1) << winner);
               owner_next       = winner;
               owner_valid_next = 1'b1;
`ifdef PCI_ARB_GNT_TIMEOUT_EN
               cnt_next         = '0;
`endif
            end
         end
         GRANTED: begin
            if (!iframe) begin
               // FRAME takes priority over a request release or expiry.
               state_next      = BUSY;
               grant_next      = '1;
               last_owner_next = owner_reg;
               bus_busy_next   = 1'b1;
            end else if (request[owner_reg]) begin
               // Owner gave up before starting; priority is not rotated.
               state_next       = IDLE;
               grant_next       = '1;
               owner_valid_next = 1'b0;
`ifdef PCI_ARB_GNT_TIMEOUT_EN
            end else if (cnt_reg + CNT_W'(1) == CNT_LIMIT) begin
               // Offender is demoted to lowest priority.
               state_next       = IDLE;
               grant_next       = '1;
               owner_valid_next = 1'b0;
               last_owner_next  = owner_reg;
               timeout_next     = 1'b1;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
`endif
            end
         end
         BUSY: begin
            grant_next = '1;
            if (bus_idle) begin
               state_next       = TURN;
               bus_busy_next    = 1'b0;
               owner_valid_next = 1'b0;
            end
         end
         TURN: begin
            grant_next = '1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= IDLE;
         grant_reg       <= '1;
         owner_reg       <= '0;
         last_owner_reg  <= IDX_W'(NUM_DEV - 1);
         owner_valid_reg <= 1'b0;
         bus_busy_reg    <= 1'b0;
`ifdef PCI_ARB_GNT_TIMEOUT_EN
         cnt_reg         <= '0;
         timeout_reg     <= 1'b0;
`endif
      end else begin
         state_reg       <= state_next;
         grant_reg       <= grant_next;
         owner_reg       <= owner_next;
         last_owner_reg  <= last_owner_next;
         owner_valid_reg <= owner_valid_next;
         bus_busy_reg    <= bus_busy_next;
`ifdef PCI_ARB_GNT_TIMEOUT_EN
         cnt_reg         <= cnt_next;
         timeout_reg     <= timeout_next;
`endif
      end
   end

   assign grant       = grant_reg;
   assign owner       = owner_reg;
   assign owner_valid = owner_valid_reg;
   assign bus_busy    = bus_busy_reg;
`ifdef PCI_ARB_GNT_TIMEOUT_EN
   assign timeout     = timeout_reg;
`else
   assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// tb_pci_bus_arbiter: directed scenarios plus randomized transactions for
// pci_bus_arbiter, with expected owners from a round-robin reference function.
module tb_pci_bus_arbiter;

   localparam int N = 3;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [N-1:0] request = '1;
   logic         iframe = 1'b1;
   logic         iready = 1'b1;
   logic [N-1:0] grant;
   logic [1:0]   owner;
   logic         owner_valid;
   logic         bus_busy;
   logic         timeout;

   int errors = 0;
   int checks = 0;
   int last;
   int expo;

   pci_bus_arbiter dut (
      .clk         (clk),
      .reset       (reset),
      .request     (request),
      .iframe      (iframe),
      .iready      (iready),
      .grant       (grant),
      .owner       (owner),
      .owner_valid (owner_valid),
      .bus_busy    (bus_busy),
      .timeout     (timeout)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic chk_out(input string tag, input logic [N-1:0] g, input logic ov,
                          input logic bb, input logic tmo);
      check({tag, ".grant"}, 32'(grant), 32'(g));
      check({tag, ".owner_valid"}, 32'(owner_valid), 32'(ov));
      check({tag, ".bus_busy"}, 32'(bus_busy), 32'(bb));
      check({tag, ".timeout"}, 32'(timeout), 32'(tmo));
   endtask

   // Round-robin reference: first requesting Device after last, wrapping.
   function automatic int rr_pick(input int last_i, input logic [N-1:0] req);
      for (int k = 1; k <= N; k++) begin
         int idx;
         idx = (last_i + k) % N;
         if (!req[idx]) return idx;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] gnt_of(input int i);
      logic [N-1:0] g;
      g = '1;
      g[i] = 1'b0;
      return g;
   endfunction

   // Granted owner runs a transaction of 'len' data cycles, then the bus
   // goes idle; checks BUSY, TURN and the idle cycle before the next grant.
   task automatic run_txn(input string tag, input int len, input bit junk_req);
      iframe  = 1'b0;
      iready  = 1'b0;
      request = junk_req ? N'($urandom) : '1;
      tick();
      chk_out({tag, ".busy"}, '1, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < len; i++) begin
         if (junk_req) request = N'($urandom);
         if (i == len - 1) iframe = 1'b1;
         tick();
         chk_out({tag, ".data"}, '1, 1'b1, 1'b1, 1'b0);
      end
      iframe  = 1'b1;
      iready  = 1'b1;
      request = '1;
      tick();
      chk_out({tag, ".turn"}, '1, 1'b0, 1'b0, 1'b0);
      tick();
      chk_out({tag, ".gap"}, '1, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      // 1: reset values, single grant, transaction, turnaround
      tick();
      chk_out("t1.reset", '1, 1'b0, 1'b0, 1'b0);
      check("t1.reset.owner", 32'(owner), 32'd0);
      reset = 1'b0;
      request = 3'b110;
      tick();
      chk_out("t1.grant", 3'b110, 1'b1, 1'b0, 1'b0);
      check("t1.owner", 32'(owner), 32'd0);
      run_txn("t1", 0, 1'b0);
      last = 0;
      $display("txn t1 owner=0");

      // 2: all request continuously; order 0,1,2,0 with 2-cycle gaps
      reset = 1'b1;
      tick();
      reset = 1'b0;
      last = N - 1;
      for (int t = 0; t < 4; t++) begin
         request = 3'b000;
         expo = rr_pick(last, 3'b000);
         check("t2.model_order", 32'(expo), 32'(t % N));
         tick();
         chk_out("t2.grant", gnt_of(expo), 1'b1, 1'b0, 1'b0);
         check("t2.owner", 32'(owner), 32'(expo));
         iframe = 1'b0;
         tick();
         chk_out("t2.busy", '1, 1'b1, 1'b1, 1'b0);
         iframe = 1'b1;
         tick();
         chk_out("t2.turn", '1, 1'b0, 1'b0, 1'b0);
         tick();
         chk_out("t2.gap", '1, 1'b0, 1'b0, 1'b0);
         last = expo;
         $display("txn t2.%0d owner=%0d", t, expo);
      end
      request = '1;

      // 3: Dev1 granted, withdraws before FRAME; pending Dev2 follows
      request = 3'b101;
      tick();
      chk_out("t3.grant1", 3'b101, 1'b1, 1'b0, 1'b0);
      check("t3.owner1", 32'(owner), 32'd1);
      request = 3'b011;
      tick();
      chk_out("t3.drop", '1, 1'b0, 1'b0, 1'b0);
      tick();
      chk_out("t3.grant2", 3'b011, 1'b1, 1'b0, 1'b0);
      check("t3.owner2", 32'(owner), 32'd2);
      run_txn("t3", 1, 1'b0);
      last = 2;
      $display("txn t3 owner=2");

      // 4: reset in the middle of a transaction
      request = 3'b110;
      tick();
      chk_out("t4.grant", 3'b110, 1'b1, 1'b0, 1'b0);
      iframe = 1'b0;
      iready = 1'b0;
      request = '1;
      tick();
      chk_out("t4.busy", '1, 1'b1, 1'b1, 1'b0);
      reset = 1'b1;
      tick();
      chk_out("t4.reset", '1, 1'b0, 1'b0, 1'b0);
      check("t4.reset.owner", 32'(owner), 32'd0);
      reset = 1'b0;
      iframe = 1'b1;
      iready = 1'b1;
      request = 3'b110;
      tick();
      chk_out("t4.regrant", 3'b110, 1'b1, 1'b0, 1'b0);
      check("t4.owner", 32'(owner), 32'd0);
      request = '1;
      tick();
      chk_out("t4.release", '1, 1'b0, 1'b0, 1'b0);
      last = N - 1;
      $display("txn t4 owner=0 (released)");

      // 5: granted Device never drives FRAME
      request = 3'b100;
      tick();
      chk_out("t5.grant", 3'b110, 1'b1, 1'b0, 1'b0);
`ifdef PCI_ARB_GNT_TIMEOUT_EN
      for (int i = 1; i < 16; i++) begin
         tick();
         chk_out("t5.wait", 3'b110, 1'b1, 1'b0, 1'b0);
      end
      tick();
      chk_out("t5.expire", '1, 1'b0, 1'b0, 1'b1);
      last = 0;
      expo = rr_pick(last, 3'b100);
      tick();
      chk_out("t5.next", gnt_of(expo), 1'b1, 1'b0, 1'b0);
      check("t5.next_owner", 32'(owner), 32'd1);
      request = '1;
      tick();
      chk_out("t5.release", '1, 1'b0, 1'b0, 1'b0);
      $display("txn t5 timeout then owner=%0d", expo);
`else
      for (int i = 0; i < 100; i++) begin
         tick();
         check("t5.hold.grant", 32'(grant), 32'(3'b110));
         check("t5.hold.timeout", 32'(timeout), 32'd0);
      end
      request = '1;
      tick();
      chk_out("t5.release", '1, 1'b0, 1'b0, 1'b0);
      $display("txn t5 held 100 cycles");
`endif

      // 6: FRAME and request release in the same cycle -> BUSY
      request = 3'b110;
      tick();
      chk_out("t6.grant", 3'b110, 1'b1, 1'b0, 1'b0);
      request = '1;
      iframe = 1'b0;
      tick();
      chk_out("t6.busy", '1, 1'b1, 1'b1, 1'b0);
      iframe = 1'b1;
      tick();
      chk_out("t6.turn", '1, 1'b0, 1'b0, 1'b0);
      tick();
      last = 0;
      $display("txn t6 owner=0");

      // 7: foreign traffic in IDLE blocks the grant until the bus is idle
      iframe = 1'b0;
      iready = 1'b0;
      request = 3'b000;
      tick();
      chk_out("t7.blocked0", '1, 1'b0, 1'b0, 1'b0);
      tick();
      chk_out("t7.blocked1", '1, 1'b0, 1'b0, 1'b0);
      iframe = 1'b1;
      iready = 1'b1;
      expo = rr_pick(last, 3'b000);
      tick();
      chk_out("t7.grant", gnt_of(expo), 1'b1, 1'b0, 1'b0);
      check("t7.owner", 32'(owner), 32'(expo));
      request = '1;
      tick();
      chk_out("t7.release", '1, 1'b0, 1'b0, 1'b0);
      $display("txn t7 owner=%0d (released)", expo);

      // Randomized transactions against the round-robin reference
      for (int r = 0; r < 40; r++) begin
         logic [N-1:0] mask;
         mask = N'($urandom_range(0, 6));
         expo = rr_pick(last, mask);
         request = mask;
         tick();
         chk_out("rnd.grant", gnt_of(expo), 1'b1, 1'b0, 1'b0);
         check("rnd.owner", 32'(owner), 32'(expo));
         if ($urandom_range(0, 3) == 0) begin
            request = '1;
            tick();
            chk_out("rnd.withdraw", '1, 1'b0, 1'b0, 1'b0);
            $display("txn rnd.%0d req=%b owner=%0d withdrawn", r, mask, expo);
         end else begin
            run_txn("rnd", int'($urandom_range(0, 3)), 1'b1);
            last = expo;
            $display("txn rnd.%0d req=%b owner=%0d", r, mask, expo);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
